// File: rtl/wb_regfile.sv
// Write-back mux plus 32-entry GPR file with two combinational read ports and a commit counter.
// Optional write-through bypass on the read ports is compiled in with `define WB_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wbMemDataIn,
    input  logic [DATA_W-1:0] wbAluDataIn,
    input  logic [ADDR_W-1:0] wbRdIn,
    input  logic              wbMemToRegIn,
    input  logic              wbRegWriteIn,
    input  logic [ADDR_W-1:0] idRsAddr,
    input  logic [ADDR_W-1:0] idRtAddr,
    output logic [DATA_W-1:0] idRsData,
    output logic [DATA_W-1:0] idRtData,
    output logic [DATA_W-1:0] wbWriteData,
    output logic              wbWriteEn,
    output logic [CNT_W-1:0]  wbCommitCount
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    assign wbWriteData   = wbMemToRegIn ? wbMemDataIn : wbAluDataIn;
    assign wbWriteEn     = wbRegWriteIn && (wbRdIn != '0);
    assign cnt_d         = cnt_q + CNT_W'(1);
    assign wbCommitCount = cnt_q;

    // Reset wins over a concurrent commit; the dropped write is not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (wbWriteEn) begin
            regs_q[wbRdIn] <= wbWriteData;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        idRsData = (idRsAddr == '0) ? '0 : regs_q[idRsAddr];
        idRtData = (idRtAddr == '0) ? '0 : regs_q[idRtAddr];
`ifdef WB_BYPASS_EN
        // Write-through: ID sees the value WB presents in this same cycle.
        if (wbWriteEn && (idRsAddr == wbRdIn)) begin
            idRsData = wbWriteData;
        end
        if (wbWriteEn && (idRtAddr == wbRdIn)) begin
            idRtData = wbWriteData;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, mux, r0, same-cycle hazard, reset priority, counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] wbMemDataIn;
    logic [31:0] wbAluDataIn;
    logic [4:0]  wbRdIn;
    logic        wbMemToRegIn;
    logic        wbRegWriteIn;
    logic [4:0]  idRsAddr;
    logic [4:0]  idRtAddr;
    logic [31:0] idRsData;
    logic [31:0] idRtData;
    logic [31:0] wbWriteData;
    logic        wbWriteEn;
    logic [31:0] wbCommitCount;

    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_wdata;
    logic        w_wen;
    logic [3:0]  w_cnt;

    int n_cmp;
    int n_err;

    wb_regfile u_dut (
        .clk          (clk),
        .rst          (rst),
        .wbMemDataIn  (wbMemDataIn),
        .wbAluDataIn  (wbAluDataIn),
        .wbRdIn       (wbRdIn),
        .wbMemToRegIn (wbMemToRegIn),
        .wbRegWriteIn (wbRegWriteIn),
        .idRsAddr     (idRsAddr),
        .idRtAddr     (idRtAddr),
        .idRsData     (idRsData),
        .idRtData     (idRtData),
        .wbWriteData  (wbWriteData),
        .wbWriteEn    (wbWriteEn),
        .wbCommitCount(wbCommitCount)
    );

    wb_regfile #(.CNT_W(4)) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .wbMemDataIn  (wbMemDataIn),
        .wbAluDataIn  (wbAluDataIn),
        .wbRdIn       (wbRdIn),
        .wbMemToRegIn (wbMemToRegIn),
        .wbRegWriteIn (wbRegWriteIn),
        .idRsAddr     (idRsAddr),
        .idRtAddr     (idRtAddr),
        .idRsData     (w_rs_data),
        .idRtData     (w_rt_data),
        .wbWriteData  (w_wdata),
        .wbWriteEn    (w_wen),
        .wbCommitCount(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [4:0] rd, input logic m2r,
                            input logic [31:0] alu, input logic [31:0] mem);
        wbRdIn       = rd;
        wbMemToRegIn = m2r;
        wbAluDataIn  = alu;
        wbMemDataIn  = mem;
        wbRegWriteIn = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        wbMemDataIn = '0;
        wbAluDataIn = '0;
        wbRdIn = '0;
        wbMemToRegIn = 1'b0;
        wbRegWriteIn = 1'b0;
        idRsAddr = 5'd5;
        idRtAddr = 5'd5;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("reset_count", wbCommitCount, 32'd0);
        chk("reset_r5", idRsData, 32'd0);
        chk("idle_wen", {31'd0, wbWriteEn}, 32'd0);

        // Populate a few registers, then reset and confirm the whole array clears.
        for (int i = 1; i <= 4; i++) begin
            drive_wr(5'(i), 1'b0, 32'hA000_0000 + 32'(i), 32'h0);
            tick();
        end
        wbRegWriteIn = 1'b0;
        idRsAddr = 5'd3;
        #1;
        chk("prefill_count", wbCommitCount, 32'd4);
        chk("prefill_r3", idRsData, 32'hA000_0003);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            idRsAddr = 5'(i);
            idRtAddr = 5'(31 - i);
            #1;
            chk($sformatf("clr_rs%0d", i), idRsData, 32'd0);
            chk($sformatf("clr_rt%0d", 31 - i), idRtData, 32'd0);
        end
        chk("clr_count", wbCommitCount, 32'd0);

        // Write-data mux and commit into r5.
        idRsAddr = 5'd5;
        idRtAddr = 5'd5;
        drive_wr(5'd5, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF);
        #1;
        chk("mux_alu", wbWriteData, 32'h1234_5678);
        chk("wen_r5", {31'd0, wbWriteEn}, 32'd1);
        tick();
        wbRegWriteIn = 1'b0;
        #1;
        chk("r5_alu", idRsData, 32'h1234_5678);
        drive_wr(5'd5, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
        #1;
        chk("mux_mem", wbWriteData, 32'hDEAD_BEEF);
        tick();
        wbRegWriteIn = 1'b0;
        #1;
        chk("r5_mem", idRsData, 32'hDEAD_BEEF);
        chk("r5_mem_rt", idRtData, 32'hDEAD_BEEF);
        chk("count_2", wbCommitCount, 32'd2);

        // r0 is hardwired zero and uncounted.
        drive_wr(5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        idRsAddr = 5'd0;
        #1;
        chk("r0_wen", {31'd0, wbWriteEn}, 32'd0);
        chk("r0_wdata", wbWriteData, 32'hFFFF_FFFF);
        tick();
        wbRegWriteIn = 1'b0;
        #1;
        chk("r0_read", idRsData, 32'd0);
        chk("r0_count", wbCommitCount, 32'd2);

        // Same-cycle read of a register being written.
        drive_wr(5'd7, 1'b0, 32'h11, 32'h0);
        tick();
        wbRegWriteIn = 1'b0;
        drive_wr(5'd7, 1'b0, 32'h22, 32'h0);
        idRsAddr = 5'd7;
        idRtAddr = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        chk("hazard_rs", idRsData, 32'h22);
        chk("hazard_rt", idRtData, 32'h22);
`else
        chk("hazard_rs", idRsData, 32'h11);
        chk("hazard_rt", idRtData, 32'h11);
`endif
        tick();
        wbRegWriteIn = 1'b0;
        #1;
        chk("hazard_next", idRsData, 32'h22);
        chk("count_4", wbCommitCount, 32'd4);

        // Unknown data with write disabled must leave state alone.
        wbAluDataIn = 'x;
        wbMemDataIn = 'x;
        wbRdIn = 5'd7;
        tick();
        #1;
        chk("xdata_r7", idRsData, 32'h22);
        chk("xdata_count", wbCommitCount, 32'd4);

        // Reset beats a concurrent write.
        drive_wr(5'd3, 1'b0, 32'hAA, 32'h0);
        rst = 1'b0;
        idRsAddr = 5'd3;
        tick();
        rst = 1'b1;
        wbRegWriteIn = 1'b0;
        #1;
        chk("rstprio_r3", idRsData, 32'd0);
        chk("rstprio_r7", idRtData, 32'd0);
        chk("rstprio_count", wbCommitCount, 32'd0);
        chk("rstprio_wcount", {28'd0, w_cnt}, 32'd0);

        // 4-bit counter wraps after 16 commits.
        for (int i = 0; i < 16; i++) begin
            drive_wr(5'(1 + (i % 31)), 1'b0, 32'(i), 32'h0);
            tick();
        end
        wbRegWriteIn = 1'b0;
        #1;
        chk("wrap_16", {28'd0, w_cnt}, 32'd0);
        drive_wr(5'd9, 1'b1, 32'h0, 32'h5A5A_5A5A);
        tick();
        wbRegWriteIn = 1'b0;
        idRsAddr = 5'd9;
        #1;
        chk("wrap_17", {28'd0, w_cnt}, 32'd1);
        chk("count_17", wbCommitCount, 32'd17);
        chk("wrap_r9", w_rs_data, 32'h5A5A_5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
